// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the ARM ID-stage decoder: opcodes, modes, ALU commands, condition codes.
// Also holds the registered control bundle, the single-op decode and condition evaluation.
package arm_ctrl_pkg;

    localparam logic [1:0] MODE_DP     = 2'b00;
    localparam logic [1:0] MODE_MEM    = 2'b01;
    localparam logic [1:0] MODE_BRANCH = 2'b10;
    localparam logic [1:0] MODE_BLOCK  = 2'b11;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    localparam logic [3:0] EXE_NOP = 4'b0000;
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MVN = 4'b1001;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    typedef enum logic {ST_IDLE, ST_BLOCK} state_e;

    typedef struct packed {
        logic       vld;
        logic [3:0] exe_cmd;
        logic       s;
        logic       b;
        logic       mem_r;
        logic       mem_w;
        logic       wb;
        logic       last;
    } ctrl_t;

    // Single-micro-op decode; unknown encodings fall through as a valid NOP.
    function automatic ctrl_t decode_ctrl(input logic [3:0] op, input logic [1:0] mode, input logic s);
        ctrl_t c;
        c      = '0;
        c.vld  = 1'b1;
        c.last = 1'b1;
        case (mode)
            MODE_DP: begin
                c.s  = s;
                c.wb = 1'b1;
                case (op)
                    OP_MOV: c.exe_cmd = EXE_MOV;
                    OP_MVN: c.exe_cmd = EXE_MVN;
                    OP_ADD: c.exe_cmd = EXE_ADD;
                    OP_ADC: c.exe_cmd = EXE_ADC;
                    OP_SUB: c.exe_cmd = EXE_SUB;
                    OP_SBC: c.exe_cmd = EXE_SBC;
                    OP_AND: c.exe_cmd = EXE_AND;
                    OP_ORR: c.exe_cmd = EXE_ORR;
                    OP_EOR: c.exe_cmd = EXE_EOR;
                    OP_CMP: begin c.exe_cmd = EXE_SUB; c.wb = 1'b0; end
                    OP_TST: begin c.exe_cmd = EXE_AND; c.wb = 1'b0; end
                    default: begin c.s = 1'b0; c.wb = 1'b0; end
                endcase
            end
            MODE_BRANCH: c.b = 1'b1;
            default: begin
                if (op == OP_ADD) begin
                    c.exe_cmd = EXE_ADD;
                    c.mem_r   = s;
                    c.mem_w   = ~s;
                    c.wb      = s;
                end
            end
        endcase
        return c;
    endfunction

    // nzcv = {N, Z, C, V}; the reserved code 1111 is treated as always.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        {n, z, c, v} = nzcv;
        case (cond)
            COND_EQ: return z;
            COND_NE: return ~z;
            COND_CS: return c;
            COND_CC: return ~c;
            COND_MI: return n;
            COND_PL: return ~n;
            COND_VS: return v;
            COND_VC: return ~v;
            COND_HI: return c & ~z;
            COND_LS: return ~c | z;
            COND_GE: return n == v;
            COND_LT: return n != v;
            COND_GT: return ~z & (n == v);
            COND_LE: return z | (n != v);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/reg_list_pe.sv
// Lowest-set-bit priority encoder over a register list; purely combinational.
// idx is 0 when the list is empty; any_set flags a non-empty list.
module reg_list_pe #(
    parameter  int W     = 16,
    localparam int IDX_W = $clog2(W)
) (
    input  logic [W-1:0]     list,
    output logic [IDX_W-1:0] idx,
    output logic             any_set
);

    always_comb begin
        idx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (list[i]) idx = IDX_W'(i);
        end
    end

    assign any_set = |list;

endmodule

// File: rtl/arm_decode_sequencer.sv
// Registered ARM ID/EX decoder expanding LDM/STM into one micro-op per listed register; 1-cycle latency.
// in_ready drops during expansion, freeze or flush. Optional ARM_DECODE_COND_EXEC_EN adds cond/status_nzcv gating.
module arm_decode_sequencer
    import arm_ctrl_pkg::*;
#(
    parameter  int NUM_REGS  = 16,
    localparam int REG_IDX_W = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef ARM_DECODE_COND_EXEC_EN
    input  logic [3:0]           cond,
    input  logic [3:0]           status_nzcv,
`endif
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           op_code,
    input  logic [1:0]           mode,
    input  logic                 s,
    input  logic [NUM_REGS-1:0]  reg_list,
    input  logic                 freeze,
    input  logic                 flush,
    output logic                 out_valid,
    output logic [3:0]           exe_cmd,
    output logic                 s_out,
    output logic                 b,
    output logic                 mem_r_en,
    output logic                 mem_w_en,
    output logic                 wb_en,
    output logic [REG_IDX_W-1:0] uop_reg,
    output logic [REG_IDX_W+1:0] uop_offset,
    output logic                 uop_last
);

    state_e                state_q, state_d;
    logic [NUM_REGS-1:0]   rem_q, rem_d;
    ctrl_t                 ctrl_q, ctrl_d;
    logic [REG_IDX_W-1:0]  reg_q, reg_d;
    logic [REG_IDX_W-1:0]  ord_q, ord_d;

    logic [NUM_REGS-1:0]   sel_list, pe_rest;
    logic [REG_IDX_W-1:0]  pe_idx;
    logic                  pe_any;
    logic                  accept, cond_ok, is_block;
    ctrl_t                 dec;

    // One encoder serves both the incoming list and the latched remainder.
    assign sel_list = (state_q == ST_IDLE) ? reg_list : rem_q;
    assign pe_rest  = sel_list & (sel_list - NUM_REGS'(1));

    reg_list_pe #(.W(NUM_REGS)) u_pe (
        .list    (sel_list),
        .idx     (pe_idx),
        .any_set (pe_any)
    );

`ifdef ARM_DECODE_COND_EXEC_EN
    assign cond_ok = cond_pass(cond, status_nzcv);
`else
    assign cond_ok = 1'b1;
`endif

    assign in_ready = (state_q == ST_IDLE) & ~freeze & ~flush;
    assign accept   = in_valid & in_ready;
    assign is_block = (mode == MODE_BLOCK) & (op_code == OP_ADD);
    assign dec      = decode_ctrl(op_code, mode, s);

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        ctrl_d  = ctrl_q;
        reg_d   = reg_q;
        ord_d   = ord_q;
        if (flush) begin
            state_d = ST_IDLE;
            rem_d   = '0;
            ctrl_d  = '0;
            reg_d   = '0;
            ord_d   = '0;
        end else if (freeze) begin
            state_d = state_q;
        end else if (state_q == ST_BLOCK) begin
            // Block controls already sit in ctrl_q; only index, ordinal and last advance.
            reg_d       = pe_idx;
            ord_d       = ord_q + REG_IDX_W'(1);
            rem_d       = pe_rest;
            ctrl_d.last = (pe_rest == '0);
            if (pe_rest == '0) state_d = ST_IDLE;
        end else if (accept) begin
            ctrl_d = '0;
            ctrl_d.vld  = 1'b1;
            ctrl_d.last = 1'b1;
            reg_d  = '0;
            ord_d  = '0;
            if (cond_ok && !(is_block && !pe_any)) begin
                ctrl_d = dec;
                if (is_block) begin
                    reg_d       = pe_idx;
                    rem_d       = pe_rest;
                    ctrl_d.last = (pe_rest == '0);
                    if (pe_rest != '0) state_d = ST_BLOCK;
                end
            end
        end else begin
            ctrl_d = '0;
            reg_d  = '0;
            ord_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            ctrl_q  <= '0;
            reg_q   <= '0;
            ord_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            ctrl_q  <= ctrl_d;
            reg_q   <= reg_d;
            ord_q   <= ord_d;
        end
    end

    assign out_valid  = ctrl_q.vld;
    assign exe_cmd    = ctrl_q.exe_cmd;
    assign s_out      = ctrl_q.s;
    assign b          = ctrl_q.b;
    assign mem_r_en   = ctrl_q.mem_r;
    assign mem_w_en   = ctrl_q.mem_w;
    assign wb_en      = ctrl_q.wb;
    assign uop_reg    = reg_q;
    assign uop_offset = {ord_q, 2'b00};
    assign uop_last   = ctrl_q.last;

endmodule

// File: tb/tb_arm_decode_sequencer.sv
// Self-checking bench for arm_decode_sequencer: decode table, block-transfer corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_arm_decode_sequencer;

    typedef struct packed {
        logic       vld;
        logic [3:0] exe;
        logic       s;
        logic       b;
        logic       mr;
        logic       mw;
        logic       wb;
        logic [3:0] rg;
        logic [5:0] off;
        logic       last;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [1:0]  md;
        logic        sb;
        logic [15:0] lst;
        exp_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  op_code = '0;
    logic [1:0]  mode = '0;
    logic        s = 1'b0;
    logic [15:0] reg_list = '0;
    logic        freeze = 1'b0;
    logic        flush = 1'b0;
`ifdef ARM_DECODE_COND_EXEC_EN
    logic [3:0]  cond = 4'b1110;
    logic [3:0]  status_nzcv = 4'b0000;
`endif
    logic        in_ready, out_valid, s_out, b, mem_r_en, mem_w_en, wb_en, uop_last;
    logic [3:0]  exe_cmd, uop_reg;
    logic [5:0]  uop_offset;

    int checks = 0;
    int errors = 0;

    int   exe_tab [16];
    exp_t cur;
    exp_t pend [$];
    vec_t vecs [19];
    int   ldm_regs [4] = '{0, 2, 4, 15};

    arm_decode_sequencer #(.NUM_REGS(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef ARM_DECODE_COND_EXEC_EN
        .cond       (cond),
        .status_nzcv(status_nzcv),
`endif
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_code    (op_code),
        .mode       (mode),
        .s          (s),
        .reg_list   (reg_list),
        .freeze     (freeze),
        .flush      (flush),
        .out_valid  (out_valid),
        .exe_cmd    (exe_cmd),
        .s_out      (s_out),
        .b          (b),
        .mem_r_en   (mem_r_en),
        .mem_w_en   (mem_w_en),
        .wb_en      (wb_en),
        .uop_reg    (uop_reg),
        .uop_offset (uop_offset),
        .uop_last   (uop_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, expv);
        end
    endtask

    function automatic exp_t get_act();
        exp_t a;
        a.vld = out_valid; a.exe = exe_cmd; a.s = s_out; a.b = b;
        a.mr = mem_r_en; a.mw = mem_w_en; a.wb = wb_en;
        a.rg = uop_reg; a.off = uop_offset; a.last = uop_last;
        return a;
    endfunction

    function automatic exp_t mk(input bit v, input int exe, input bit s_, input bit b_, input bit mr,
                                input bit mw, input bit wb, input int rg, input int off, input bit last);
        exp_t e;
        e.vld = v; e.exe = 4'(exe); e.s = s_; e.b = b_; e.mr = mr; e.mw = mw; e.wb = wb;
        e.rg = 4'(rg); e.off = 6'(off); e.last = last;
        return e;
    endfunction

    function automatic vec_t mkv(input int op, input int md, input bit sb, input int lst, input exp_t e);
        vec_t v;
        v.op = 4'(op); v.md = 2'(md); v.sb = sb; v.lst = 16'(lst); v.exp = e;
        return v;
    endfunction

    // Reference: each accepted instruction becomes a list of micro-ops; the list drains one per unfrozen cycle.
    task automatic model_step(input bit v, input bit [3:0] op, input bit [1:0] md, input bit sb,
                              input bit [15:0] lst, input bit fz, input bit fl);
        exp_t u;
        int   k, n;
        u = '0;
        k = 0;
        n = $countones(lst);
        if (fl) begin
            cur = '0;
            pend.delete();
        end else if (fz) begin
            cur = cur;
        end else if (pend.size() != 0) begin
            cur = pend.pop_front();
        end else if (v) begin
            u.vld = 1'b1;
            u.last = 1'b1;
            if (md == 2'b11 && op == 4'b0100 && n != 0) begin
                for (int i = 0; i < 16; i++) begin
                    if (lst[i]) begin
                        u.exe = 4'd2; u.mr = sb; u.mw = !sb; u.wb = sb;
                        u.rg = 4'(i); u.off = 6'(4 * k); u.last = (k == n - 1);
                        pend.push_back(u);
                        k++;
                    end
                end
                cur = pend.pop_front();
            end else begin
                if (md == 2'b00 && exe_tab[op] >= 0) begin
                    u.exe = 4'(exe_tab[op]);
                    u.s = sb;
                    u.wb = !(op == 4'b1010 || op == 4'b1000);
                end else if (md == 2'b01 && op == 4'b0100) begin
                    u.exe = 4'd2; u.mr = sb; u.mw = !sb; u.wb = sb;
                end else if (md == 2'b10) begin
                    u.b = 1'b1;
                end
                cur = u;
            end
        end else begin
            cur = '0;
        end
    endtask

    task automatic present(input int op, input int md, input bit sb, input int lst);
        @(negedge clk);
        in_valid = 1'b1; op_code = 4'(op); mode = 2'(md); s = sb; reg_list = 16'(lst);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        exp_t nop;
        bit   exp_rdy;
        nop = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        foreach (exe_tab[i]) exe_tab[i] = -1;
        exe_tab[13] = 1; exe_tab[15] = 9; exe_tab[4] = 2; exe_tab[5] = 3; exe_tab[2] = 4;
        exe_tab[6] = 5;  exe_tab[0] = 6;  exe_tab[12] = 7; exe_tab[1] = 8; exe_tab[10] = 4; exe_tab[8] = 6;

        vecs[0]  = mkv(4'h4, 0, 1, 0, mk(1, 2, 1, 0, 0, 0, 1, 0, 0, 1));
        vecs[1]  = mkv(4'hA, 0, 1, 0, mk(1, 4, 1, 0, 0, 0, 0, 0, 0, 1));
        vecs[2]  = mkv(4'h8, 0, 0, 0, mk(1, 6, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs[3]  = mkv(4'hD, 0, 0, 0, mk(1, 1, 0, 0, 0, 0, 1, 0, 0, 1));
        vecs[4]  = mkv(4'hF, 0, 1, 0, mk(1, 9, 1, 0, 0, 0, 1, 0, 0, 1));
        vecs[5]  = mkv(4'h1, 0, 0, 0, mk(1, 8, 0, 0, 0, 0, 1, 0, 0, 1));
        vecs[6]  = mkv(4'h6, 0, 1, 0, mk(1, 5, 1, 0, 0, 0, 1, 0, 0, 1));
        vecs[7]  = mkv(4'h3, 0, 1, 0, nop);
        vecs[8]  = mkv(4'h4, 1, 1, 0, mk(1, 2, 0, 0, 1, 0, 1, 0, 0, 1));
        vecs[9]  = mkv(4'h4, 1, 0, 0, mk(1, 2, 0, 0, 0, 1, 0, 0, 0, 1));
        vecs[10] = mkv(4'h2, 1, 1, 0, nop);
        vecs[11] = mkv(4'h7, 2, 1, 0, mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        vecs[12] = mkv(4'h4, 3, 1, 0, nop);
        vecs[13] = mkv(4'h0, 3, 1, 16'hFFFF, nop);
        vecs[14] = mkv(4'h4, 3, 1, 16'h0400, mk(1, 2, 0, 0, 1, 0, 1, 10, 0, 1));
        vecs[15] = mkv(4'hC, 0, 1, 0, mk(1, 7, 1, 0, 0, 0, 1, 0, 0, 1));
        vecs[16] = mkv(4'h5, 0, 0, 0, mk(1, 3, 0, 0, 0, 0, 1, 0, 0, 1));
        vecs[17] = mkv(4'h0, 0, 1, 0, mk(1, 6, 1, 0, 0, 0, 1, 0, 0, 1));
        vecs[18] = mkv(4'h2, 0, 0, 0, mk(1, 4, 0, 0, 0, 0, 1, 0, 0, 1));

        // Reset state
        #12;
        check("reset_out", get_act(), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_out_rel", get_act(), 32'h0);
        check("reset_rdy", in_ready, 1);

        // Single-op decode table; each entry followed by an idle cycle.
        for (int i = 0; i < 19; i++) begin
            present(vecs[i].op, vecs[i].md, vecs[i].sb, vecs[i].lst);
            check($sformatf("vec%0d", i), get_act(), vecs[i].exp);
            @(posedge clk); #1;
            check($sformatf("vec%0d_idle", i), get_act(), 32'h0);
        end

        // LDM r0,r2,r4,r15
        present(4'h4, 3, 1, 16'h8015);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("ldm_uop%0d", k), get_act(), mk(1, 2, 0, 0, 1, 0, 1, ldm_regs[k], 4 * k, k == 3));
            check($sformatf("ldm_rdy%0d", k), in_ready, (k == 3) ? 1 : 0);
            if (k < 3) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        check("ldm_after", get_act(), 32'h0);

        // STM r1,r2 with freeze on the second output cycle
        present(4'h4, 3, 0, 16'h0006);
        check("stm_r1", get_act(), mk(1, 2, 0, 0, 0, 1, 0, 1, 0, 0));
        @(posedge clk); #1;
        check("stm_r2", get_act(), mk(1, 2, 0, 0, 0, 1, 0, 2, 4, 1));
        @(negedge clk); freeze = 1'b1;
        #1 check("stm_frz_rdy", in_ready, 0);
        @(posedge clk); #1;
        check("stm_r2_hold", get_act(), mk(1, 2, 0, 0, 0, 1, 0, 2, 4, 1));
        @(negedge clk); freeze = 1'b0;
        @(posedge clk); #1;
        check("stm_idle", get_act(), 32'h0);
        check("stm_idle_rdy", in_ready, 1);

        // LDM 0x00FF aborted by flush+freeze on the third output cycle
        present(4'h4, 3, 1, 16'h00FF);
        check("flush_r0", get_act(), mk(1, 2, 0, 0, 1, 0, 1, 0, 0, 0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("flush_r2", get_act(), mk(1, 2, 0, 0, 1, 0, 1, 2, 8, 0));
        @(negedge clk); flush = 1'b1; freeze = 1'b1;
        @(posedge clk); #1;
        check("flush_out", get_act(), 32'h0);
        @(negedge clk); flush = 1'b0; freeze = 1'b0;
        #1 check("flush_rdy", in_ready, 1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("flush_quiet", get_act(), 32'h0);
        end

        // Async reset in the middle of an expansion
        present(4'h4, 3, 1, 16'hFFFF);
        @(posedge clk); #1;
        check("arst_pre", get_act(), mk(1, 2, 0, 0, 1, 0, 1, 1, 4, 0));
        #2 rst_n = 1'b0;
        #1 check("arst_out", get_act(), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("arst_rdy", in_ready, 1);
        check("arst_idle", get_act(), 32'h0);

`ifdef ARM_DECODE_COND_EXEC_EN
        cond = 4'b0000; status_nzcv = 4'b0000;
        present(4'hD, 0, 0, 0);
        check("cond_eq_fail", get_act(), nop);
        status_nzcv = 4'b0100;
        present(4'hD, 0, 0, 0);
        check("cond_eq_pass", get_act(), mk(1, 1, 0, 0, 0, 0, 1, 0, 0, 1));
        cond = 4'b0001;
        present(4'h4, 3, 1, 16'h00F0);
        check("cond_blk_fail", get_act(), nop);
        check("cond_blk_rdy", in_ready, 1);
        cond = 4'b1110;
        @(posedge clk); #1;
`endif

        // Randomized traffic against the reference model
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        cur = '0;
        pend.delete();
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 9) < 7);
            mode     = 2'($urandom_range(0, 3));
            op_code  = ($urandom_range(0, 1) == 1) ? 4'h4 : 4'($urandom_range(0, 15));
            s        = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       reg_list = '0;
                1:       reg_list = 16'(1) << $urandom_range(0, 15);
                2:       reg_list = 16'($urandom);
                default: reg_list = 16'($urandom & $urandom);
            endcase
            freeze = ($urandom_range(0, 99) < 15);
            flush  = ($urandom_range(0, 99) < 5);
            exp_rdy = (pend.size() == 0) && !freeze && !flush;
            #1 check("rand_rdy", in_ready, exp_rdy);
            @(posedge clk);
            model_step(in_valid, op_code, mode, s, reg_list, freeze, flush);
            #1 check("rand_out", get_act(), cur);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arm_decode_sequencer.md
# arm_decode_sequencer

Registered, parametrised successor to the combinational ARM control decoder in the ID stage. Decodes `op_code`/`mode`/`s` into execute/memory/write-back controls, registers them into the ID/EX boundary, and honours hazard-unit freeze and branch flush. Adds block transfers (LDM/STM): one accepted instruction is expanded into one micro-op per set bit of a register list, with input back-pressure while expansion runs.

## Interface
- `NUM_REGS`, 16: register-list width; must be a power of two ≥ 2.
- `REG_IDX_W`, $clog2(NUM_REGS): register index width (derived; not overridden).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  instruction present.
- `in_ready`  out  1  instruction accepted when `in_valid & in_ready`.
- `op_code`  in  4  ARM data-processing opcode.
- `mode`  in  2  00 data-proc, 01 LDR/STR, 10 branch, 11 block/NOP.
- `s`  in  1  S bit; for memory ops, load(1)/store(0).
- `reg_list`  in  NUM_REGS  block-transfer register list.
- `freeze`  in  1  hazard stall.
- `flush`  in  1  branch-taken kill.
- `out_valid`  out  1  registered micro-op valid.
- `exe_cmd`  out  4  ALU command.
- `s_out`, `b`, `mem_r_en`, `mem_w_en`, `wb_en`  out  1 each  registered controls.
- `uop_reg`  out  REG_IDX_W  transfer register index; 0 for non-block ops.
- `uop_offset`  out  REG_IDX_W+2  byte offset, 4×ordinal within the transfer.
- `uop_last`  out  1  final micro-op of its instruction.

## Operation
- Decode, `mode` 00: MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000.
  - These set `wb_en=1`, `s_out=s`.
  - CMP: `exe_cmd` 0100. TST: `exe_cmd` 0110. Both `wb_en=0`, `s_out=s`.
  - Other opcodes decode as NOP.
- `mode` 01 with `op_code` 0100:
  - `s`=1 (LDR): `exe_cmd` 0010, `mem_r_en=1`, `wb_en=1`.
  - `s`=0 (STR): `exe_cmd` 0010, `mem_w_en=1`.
  - Other opcodes decode as NOP.
- `mode` 10: `b=1`, `exe_cmd` 0000.
- `mode` 11 with `op_code` 0100: block transfer. LDM if `s`=1 (`mem_r_en`, `wb_en`); STM if `s`=0 (`mem_w_en`). `exe_cmd` 0010.
  - Any other `mode` 11 opcode decodes as NOP.
- `s_out`=0 for all memory, branch and NOP ops.
- NOP: `out_valid=1`, all enables 0, `exe_cmd` 0000, `uop_last=1`.
- FSM states: IDLE, BLOCK.
  - IDLE, on accept of a block op with nonzero list:
    - register micro-op for the lowest set bit, ordinal 0;
    - latch the remaining list with that bit cleared;
    - go to BLOCK if the remaining list ≠ 0, else stay in IDLE with `uop_last=1`.
  - BLOCK, each unfrozen cycle:
    - emit the lowest remaining set bit at the next ordinal and clear that bit;
    - when the list becomes empty, set `uop_last=1` and go to IDLE.
- Block op with empty `reg_list`: single NOP micro-op.
- IDLE with no accept: `out_valid=0`, all controls 0.
- `in_ready = (state==IDLE) & ~freeze & ~flush`.

## Timing
- Reset: state IDLE, remaining list 0; every output register 0, including `out_valid`, `exe_cmd`, `uop_*`.
- Latency: one cycle, accept at edge N → micro-op visible after edge N.
- An N-bit list gives N consecutive `out_valid` cycles with no bubbles. `in_ready` is low for the N−1 cycles after accept.
- `freeze` (no `flush`): state, remaining list, ordinal and all outputs hold; nothing accepted.
- `flush`: has priority over `freeze`.
  - Next edge clears all outputs and the remaining list; state goes to IDLE.
  - The instruction presented that cycle is not accepted.
- `flush` in BLOCK aborts the expansion; remaining micro-ops are discarded.
- Async reset mid-BLOCK: immediate return to reset values.

## Configuration
- `ARM_DECODE_COND_EXEC_EN` defined:
  - adds ports `cond` (in, 4) and `status_nzcv` (in, 4);
  - cond codes EQ…AL are evaluated at accept;
  - a failing condition registers a NOP (`out_valid=1`, enables 0, `uop_last=1`), and a failing block op does not enter BLOCK.
- Undefined: no such ports; every instruction executes.

## Structure
- Package `arm_ctrl_pkg` holds:
  - opcode and mode localparams;
  - EXE_CMD encodings;
  - condition-code encodings;
  - FSM state enum.
- One sub-module, `reg_list_pe`: parametrised lowest-set-bit priority encoder with outputs index and any-set.

## Test plan
- Reset with `rst_n=0` mid-operation → all outputs 0, `in_ready=1` after release.
- ADD (`mode` 00, op 0100, `s`=1) → next cycle `exe_cmd`=0010, `wb_en=1`, `s_out=1`, `uop_last=1`; CMP → `exe_cmd`=0100, `wb_en=0`.
- LDM with `reg_list`=16'h8015 → four micro-ops with `uop_reg` 0,2,4,15 and `uop_offset` 0,4,8,12.
  - `uop_last` only on the fourth micro-op.
  - `in_ready` low for three cycles.
- STM with `reg_list`=16'h0006, `freeze` on the second output cycle → micro-op for r2 held two cycles, then `uop_last`, then IDLE.
- LDM with `reg_list`=16'h00FF, `flush` with `freeze` on the third output cycle → next cycle `out_valid=0`, `in_ready=1`, no further micro-ops.
- With `ARM_DECODE_COND_EXEC_EN`: MOV with cond EQ and Z=0 → NOP with `wb_en=0`; the same with Z=1 → `wb_en=1`, `exe_cmd`=0001.
